// File: rtl/debug_monitor_pkg.sv
// rtl/debug_monitor_pkg.sv - mode encoding and timing helpers shared by the debug monitor
package debug_monitor_pkg;

  typedef enum logic [1:0] {
    MON_MANUAL = 2'b00,
    MON_SCAN   = 2'b01,
    MON_HOLD   = 2'b10,
    MON_RSVD   = 2'b11
  } mon_mode_t;

  localparam int unsigned CLK_HZ = 50_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 1000);
  endfunction

endpackage

// File: rtl/debug_monitor_key_debounce.sv
// rtl/debug_monitor_key_debounce.sv - push-button synchroniser, debouncer and press pulse
module key_debounce
  import debug_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10)
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyN,
  output logic Level,
  output logic Press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Level starts released; a key held through reset must re-qualify from scratch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= KeyN;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_press   <= r_level_q & ~r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Level = r_level;
  assign Press = r_press;

endmodule

// File: rtl/debug_monitor.sv
// rtl/debug_monitor.sv - sequential probe selector with auto-scan and hold; DEBUG_MON_PREV_EN adds a previous-channel key
module debug_monitor
  import debug_monitor_pkg::*;
#(
  parameter  int unsigned WIDTH           = 16,
  parameter  int unsigned CHANNELS        = 8,
  parameter  int unsigned DEBOUNCE_CYCLES = ms_to_cycles(10),
  parameter  int unsigned SCAN_CYCLES     = ms_to_cycles(1000),
  localparam int unsigned CH_W            = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      KeyNextN,
`ifdef DEBUG_MON_PREV_EN
  input  logic                      KeyPrevN,
  output logic                      StepPrev,
`endif
  input  logic [1:0]                Mode,
  input  logic [CHANNELS*WIDTH-1:0] Probes,
  output logic [CH_W-1:0]           Channel,
  output logic [WIDTH-1:0]          Display,
  output logic                      Step,
  output logic                      Frozen
);

  localparam int unsigned SC_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

  mon_mode_t        w_mode;
  logic             w_scan;
  logic             w_hold;
  logic             w_mode_chg;
  logic             w_tc;
  logic             w_step;
  logic             w_keys;
  logic             w_fwd;
  logic             w_back;
  logic             w_move;
  logic             w_next_level_unused;
  logic [CH_W-1:0]  w_ch_next;
  logic [1:0]       r_mode_q;
  logic [SC_W-1:0]  r_scan_cnt;
  logic [CH_W-1:0]  r_channel;
  logic [WIDTH-1:0] r_display;
  logic             r_frozen;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .Clock (Clock),
    .Reset (Reset),
    .KeyN  (KeyNextN),
    .Level (w_next_level_unused),
    .Press (w_step)
  );

  assign w_mode     = mon_mode_t'(Mode);
  assign w_scan     = (w_mode == MON_SCAN);
  assign w_hold     = (w_mode == MON_HOLD);
  assign w_mode_chg = (Mode != r_mode_q);
  assign w_tc       = w_scan && (r_scan_cnt == SC_LAST);

`ifdef DEBUG_MON_PREV_EN
  logic w_prev;
  logic w_prev_level_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
    .Clock (Clock),
    .Reset (Reset),
    .KeyN  (KeyPrevN),
    .Level (w_prev_level_unused),
    .Press (w_prev)
  );

  // Opposing presses cancel; a previous-key press also overrides a coincident scan advance.
  assign w_fwd    = ~w_prev & (w_step | w_tc);
  assign w_back   = w_prev & ~w_step;
  assign w_keys   = w_step | w_prev;
  assign StepPrev = w_prev;
`else
  assign w_fwd  = w_step | w_tc;
  assign w_back = 1'b0;
  assign w_keys = w_step;
`endif

  assign w_move = w_fwd | w_back;

  always_comb begin
    w_ch_next = r_channel;
    if (w_fwd) begin
      w_ch_next = (r_channel == CH_LAST) ? '0 : r_channel + 1'b1;
    end else if (w_back) begin
      w_ch_next = (r_channel == '0) ? CH_LAST : r_channel - 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mode_q   <= 2'b00;
      r_scan_cnt <= '0;
      r_channel  <= '0;
      r_display  <= '0;
      r_frozen   <= 1'b0;
    end else begin
      r_mode_q  <= Mode;
      r_channel <= w_ch_next;
      r_frozen  <= w_hold;
      if (!w_scan || w_mode_chg || w_keys || w_tc) begin
        r_scan_cnt <= '0;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      // Outside HOLD the display follows the selected probe; in HOLD it only refreshes on a channel move.
      if (!w_hold || w_move) begin
        r_display <= Probes[w_ch_next*WIDTH +: WIDTH];
      end
    end
  end

  assign Channel = r_channel;
  assign Display = r_display;
  assign Step    = w_step;
  assign Frozen  = r_frozen;

endmodule
